// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR coefficient loader.
package fir_pkg;

  localparam int unsigned DataWDefault = 16;
  localparam int unsigned GapCycMin    = 2;

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StWaitHi,
    StWaitLo,
    StSettle,
    StWrA,
    StWrB,
    StGap,
    StDone
  } fir_state_e;

endpackage

// File: rtl/fir_coef_loader.sv
// Drives the window generator over half of a symmetric (n+1)-tap FIR and mirrors each
// returned coefficient into coefficient RAM at addresses i and n-i.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned GAP_CYC = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              gen_en,
  output logic [15:0]       gen_i,
  output logic [15:0]       gen_n,
  input  logic              gen_busy,
  input  logic [DATA_W-1:0] gen_coef,
  output logic              coef_we,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [DATA_W-1:0] coef_data
);

  localparam logic [7:0] TimeoutLoad = 8'(TIMEOUT - 1);
  localparam logic [7:0] GapLoad     = 8'(GAP_CYC - 1);

  fir_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [15:0]       i_q, i_d;
  logic [15:0]       n_q, n_d;
  logic [DATA_W-1:0] coef_q, coef_d;
  logic              err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      i_q     <= '0;
      n_q     <= '0;
      coef_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      n_q     <= n_d;
      coef_q  <= coef_d;
      err_q   <= err_d;
    end
  end

  // One shared down-counter: reloaded on entry to each wait/gap state, expires at zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    n_d     = n_q;
    coef_d  = coef_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          n_d     = n;
          i_d     = '0;
          err_d   = 1'b0;
          state_d = StReq;
        end
      end
      StReq: begin
        cnt_d   = TimeoutLoad;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (gen_busy) begin
          cnt_d   = TimeoutLoad;
          state_d = StWaitLo;
        end else if (cnt_q == 8'd0) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StWaitLo: begin
        if (!gen_busy) begin
          state_d = StSettle;
        end else if (cnt_q == 8'd0) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSettle: begin
        // Generator output lags busy falling by one cycle.
        coef_d  = gen_coef;
        state_d = StWrA;
      end
      StWrA: begin
        if (i_q == n_q - i_q) begin
          cnt_d   = GapLoad;
          state_d = StGap;
        end else begin
          state_d = StWrB;
        end
      end
      StWrB: begin
        cnt_d   = GapLoad;
        state_d = StGap;
      end
      StGap: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (i_q >= (n_q >> 1)) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 16'd1;
          state_d = StReq;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q != StIdle) && (state_q != StDone);
    done      = (state_q == StDone);
    error     = err_q;
    gen_en    = (state_q == StReq) || (state_q == StWaitHi);
    gen_i     = i_q;
    gen_n     = n_q;
    coef_we   = (state_q == StWrA) || (state_q == StWrB);
    // Mirror address computed modulo the RAM size; identical to the low bits of n-i.
    coef_addr = (state_q == StWrB) ? (n_q[ADDR_W-1:0] - i_q[ADDR_W-1:0]) : i_q[ADDR_W-1:0];
    coef_data = coef_q;
  end

endmodule
